// File: rtl/tl_rx_credit_adv_if.sv
// FC request channel between the RX credit advertiser
// and the DLLP generator (valid/ready handshake).
interface tl_rx_credit_adv_if #(
    parameter int HDR_WIDTH  = 8,
    parameter int DATA_WIDTH = 12
);
    logic                  fc_req_valid_o;
    logic                  fc_req_ready_i;
    logic                  fc_req_init_o;
    logic [1:0]            fc_req_type_o;
    logic [HDR_WIDTH-1:0]  fc_req_hdr_o;
    logic [DATA_WIDTH-1:0] fc_req_data_o;

    modport master (
        output fc_req_valid_o,
        output fc_req_init_o,
        output fc_req_type_o,
        output fc_req_hdr_o,
        output fc_req_data_o,
        input  fc_req_ready_i
    );

    modport slave (
        input  fc_req_valid_o,
        input  fc_req_init_o,
        input  fc_req_type_o,
        input  fc_req_hdr_o,
        input  fc_req_data_o,
        output fc_req_ready_i
    );
endinterface

// File: rtl/tl_rx_credit_adv.sv
// RX flow-control credit advertiser: owns CREDITS_ALLOCATED,
// sequences InitFC after link-up and schedules UpdateFC requests.
module tl_rx_credit_adv #(
    parameter int HDR_WIDTH     = 8,
    parameter int DATA_WIDTH    = 12,
    parameter int INIT_PH       = 32,
    parameter int INIT_NPH      = 16,
    parameter int INIT_CPLH     = 0,
    parameter int INIT_PD       = 256,
    parameter int INIT_NPD      = 16,
    parameter int INIT_CPLD     = 0,
    parameter int INIT_ROUNDS   = 2,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  link_up_i,
    input  logic                  ph_rel_v_i,
    input  logic                  pd_rel_v_i,
    input  logic                  nph_rel_v_i,
    input  logic                  npd_rel_v_i,
    input  logic                  cplh_rel_v_i,
    input  logic                  cpld_rel_v_i,
    input  logic [HDR_WIDTH-1:0]  ph_rel_amt_i,
    input  logic [HDR_WIDTH-1:0]  nph_rel_amt_i,
    input  logic [HDR_WIDTH-1:0]  cplh_rel_amt_i,
    input  logic [DATA_WIDTH-1:0] pd_rel_amt_i,
    input  logic [DATA_WIDTH-1:0] npd_rel_amt_i,
    input  logic [DATA_WIDTH-1:0] cpld_rel_amt_i,
    tl_rx_credit_adv_if.master    fc,
    output logic                  init_done_o
);
    localparam logic [1:0] S_DOWN = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam int TW = $clog2(UPDATE_PERIOD);
    localparam int RW = $clog2(INIT_ROUNDS + 1);

    localparam logic [2:0][HDR_WIDTH-1:0] H_INIT = {
        HDR_WIDTH'(INIT_CPLH), HDR_WIDTH'(INIT_NPH), HDR_WIDTH'(INIT_PH)};
    localparam logic [2:0][DATA_WIDTH-1:0] D_INIT = {
        DATA_WIDTH'(INIT_CPLD), DATA_WIDTH'(INIT_NPD), DATA_WIDTH'(INIT_PD)};
    localparam logic [2:0] H_INF = {INIT_CPLH == 0, INIT_NPH == 0, INIT_PH == 0};
    localparam logic [2:0] D_INF = {INIT_CPLD == 0, INIT_NPD == 0, INIT_PD == 0};

    function automatic logic [1:0] f_nxt(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    logic [1:0]                  r_state;
    logic [2:0][HDR_WIDTH-1:0]   r_hcnt;
    logic [2:0][DATA_WIDTH-1:0]  r_dcnt;
    logic [2:0]                  r_pend;
    logic [1:0]                  r_ptr;
    logic [1:0]                  r_icls;
    logic [RW-1:0]               r_round;
    logic [TW-1:0]               r_timer;
    logic                        r_valid;
    logic                        r_init;
    logic [1:0]                  r_type;
    logic [HDR_WIDTH-1:0]        r_hdr;
    logic [DATA_WIDTH-1:0]       r_data;
    logic                        r_done;

    logic [2:0]                  w_hrel;
    logic [2:0]                  w_drel;
    logic [2:0][HDR_WIDTH-1:0]   w_hamt;
    logic [2:0][DATA_WIDTH-1:0]  w_damt;
    logic [2:0][HDR_WIDTH-1:0]   w_hcnt_nxt;
    logic [2:0][DATA_WIDTH-1:0]  w_dcnt_nxt;
    logic [2:0]                  w_hup;
    logic [2:0]                  w_dup;
    logic [2:0]                  w_set;
    logic [2:0]                  w_pend;
    logic [1:0]                  w_c1;
    logic [1:0]                  w_c2;
    logic [1:0]                  w_gcls;
    logic                        w_run;
    logic                        w_exp;
    logic                        w_hs;
    logic                        w_last;
    logic                        w_issue;

    assign w_hrel = {cplh_rel_v_i, nph_rel_v_i, ph_rel_v_i};
    assign w_drel = {cpld_rel_v_i, npd_rel_v_i, pd_rel_v_i};
    assign w_hamt = {cplh_rel_amt_i, nph_rel_amt_i, ph_rel_amt_i};
    assign w_damt = {cpld_rel_amt_i, npd_rel_amt_i, pd_rel_amt_i};

    assign w_hs    = r_valid && fc.fc_req_ready_i;
    assign w_last  = (r_icls == 2'd2) && (r_round == RW'(INIT_ROUNDS - 1));
    assign w_issue = w_run && !r_valid && (|w_pend);

    assign fc.fc_req_valid_o = r_valid;
    assign fc.fc_req_init_o  = r_init;
    assign fc.fc_req_type_o  = r_type;
    assign fc.fc_req_hdr_o   = r_hdr;
    assign fc.fc_req_data_o  = r_data;
    assign init_done_o       = r_done;

    // Next counter values and pending-set events; releases only count in RUN
    always_comb begin
        w_run = (r_state == S_RUN);
        w_exp = w_run && (r_timer == TW'(UPDATE_PERIOD - 1));
        for (int c = 0; c < 3; c++) begin
            w_hup[c] = w_run && w_hrel[c] && !H_INF[c];
            w_dup[c] = w_run && w_drel[c] && !D_INF[c];
            w_hcnt_nxt[c] = w_hup[c] ? r_hcnt[c] + w_hamt[c] : r_hcnt[c];
            w_dcnt_nxt[c] = w_dup[c] ? r_dcnt[c] + w_damt[c] : r_dcnt[c];
            w_set[c] = w_hup[c] || w_dup[c] || w_exp;
        end
        w_pend = r_pend | w_set;
    end

    // Round-robin pick among pending classes, starting at r_ptr
    always_comb begin
        w_c1   = f_nxt(r_ptr);
        w_c2   = f_nxt(w_c1);
        w_gcls = r_ptr;
        if (w_pend[w_c2]) w_gcls = w_c2;
        if (w_pend[w_c1]) w_gcls = w_c1;
        if (w_pend[r_ptr]) w_gcls = r_ptr;
    end

    // CREDITS_ALLOCATED counters, held at their initial values until RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= H_INIT;
            r_dcnt <= D_INIT;
        end else if (!link_up_i || r_state == S_DOWN) begin
            r_hcnt <= H_INIT;
            r_dcnt <= D_INIT;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_dcnt <= w_dcnt_nxt;
        end
    end

    // Refresh timer, pending flags and arbitration pointer (RUN only);
    // a flag drops once its class payload is captured, later releases re-arm it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_pend  <= '0;
            r_ptr   <= 2'd0;
        end else if (!link_up_i || !w_run) begin
            r_timer <= '0;
            r_pend  <= '0;
            r_ptr   <= 2'd0;
        end else begin
            r_timer <= w_exp ? '0 : r_timer + 1'b1;
            if (w_issue) begin
                r_pend <= w_pend & ~(3'b001 << w_gcls);
                r_ptr  <= f_nxt(w_gcls);
            end else begin
                r_pend <= w_pend;
            end
        end
    end

    // Link FSM and the single outstanding request register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DOWN;
            r_valid <= 1'b0;
            r_init  <= 1'b0;
            r_type  <= 2'd0;
            r_hdr   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_icls  <= 2'd0;
            r_round <= '0;
        end else if (!link_up_i) begin
            r_state <= S_DOWN;
            r_valid <= 1'b0;
            r_init  <= 1'b0;
            r_type  <= 2'd0;
            r_hdr   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_icls  <= 2'd0;
            r_round <= '0;
        end else begin
            unique case (r_state)
                S_DOWN: begin
                    r_state <= S_INIT;
                    r_valid <= 1'b1;
                    r_init  <= 1'b1;
                    r_type  <= 2'd0;
                    r_hdr   <= H_INIT[0];
                    r_data  <= D_INIT[0];
                    r_icls  <= 2'd0;
                    r_round <= '0;
                end
                S_INIT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= S_RUN;
                            r_done  <= 1'b1;
                        end else if (r_icls == 2'd2) begin
                            r_icls  <= 2'd0;
                            r_round <= r_round + 1'b1;
                        end else begin
                            r_icls <= r_icls + 2'd1;
                        end
                    end else if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_init  <= 1'b1;
                        r_type  <= r_icls;
                        r_hdr   <= r_hcnt[r_icls];
                        r_data  <= r_dcnt[r_icls];
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                    end else if (w_issue) begin
                        r_valid <= 1'b1;
                        r_init  <= 1'b0;
                        r_type  <= w_gcls;
                        r_hdr   <= w_hcnt_nxt[w_gcls];
                        r_data  <= w_dcnt_nxt[w_gcls];
                    end
                end
                default: begin
                    r_state <= S_DOWN;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tl_rx_credit_adv.sv
// Bench for tl_rx_credit_adv: directed scenarios plus random traffic,
// checked every cycle against a transaction-level credit model.
module tb_tl_rx_credit_adv;
    localparam int HW     = 8;
    localparam int DW     = 12;
    localparam int PERIOD = 128;
    localparam int ROUNDS = 2;
    localparam int HI[3]  = '{32, 16, 0};
    localparam int DI[3]  = '{256, 16, 0};

    typedef struct packed {
        logic          i;
        logic [1:0]    t;
        logic [HW-1:0] h;
        logic [DW-1:0] d;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          link_up;
    logic [2:0]    hrel;
    logic [2:0]    drel;
    logic [HW-1:0] hamt[3];
    logic [DW-1:0] damt[3];
    logic          init_done;

    tl_rx_credit_adv_if #(.HDR_WIDTH(HW), .DATA_WIDTH(DW)) fc();

    tl_rx_credit_adv #(.UPDATE_PERIOD(PERIOD)) dut (
        .clk            (clk),
        .rst            (rst),
        .link_up_i      (link_up),
        .ph_rel_v_i     (hrel[0]),
        .pd_rel_v_i     (drel[0]),
        .nph_rel_v_i    (hrel[1]),
        .npd_rel_v_i    (drel[1]),
        .cplh_rel_v_i   (hrel[2]),
        .cpld_rel_v_i   (drel[2]),
        .ph_rel_amt_i   (hamt[0]),
        .nph_rel_amt_i  (hamt[1]),
        .cplh_rel_amt_i (hamt[2]),
        .pd_rel_amt_i   (damt[0]),
        .npd_rel_amt_i  (damt[1]),
        .cpld_rel_amt_i (damt[2]),
        .fc             (fc),
        .init_done_o    (init_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    acc_t q_acc[$];

    // Model: link phase, allocated credits, "not yet advertised" marks,
    // the one expected outstanding request and the refresh tick count
    int mstate;
    int mh[3];
    int md[3];
    bit mpend[3];
    bit mv;
    bit mi;
    int mt;
    int mhdr;
    int mdata;
    int mninit;
    int mnext;
    int mtick;
    bit mdone;

    task automatic check(string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d",
                         name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        mstate = 0;
        for (int c = 0; c < 3; c++) begin
            mh[c] = HI[c];
            md[c] = DI[c];
            mpend[c] = 1'b0;
        end
        mv = 0; mi = 0; mt = 0; mhdr = 0; mdata = 0;
        mninit = 0; mnext = 0; mtick = 0; mdone = 0;
    endtask

    task automatic m_issue(int c, bit init);
        mv = 1; mi = init; mt = c; mhdr = mh[c]; mdata = md[c];
    endtask

    task automatic model_edge();
        bit hs;
        bit exp_now;
        int c;
        hs = mv && fc.fc_req_ready_i;
        if (!link_up) begin
            m_reset();
            return;
        end
        case (mstate)
            0: begin
                mstate = 1;
                mninit = 0;
                m_issue(0, 1'b1);
            end
            1: begin
                if (hs) begin
                    mv = 0;
                    mninit++;
                    if (mninit == 3 * ROUNDS) begin
                        mstate = 2;
                        mdone = 1;
                    end
                end else if (!mv) begin
                    m_issue(mninit % 3, 1'b1);
                end
            end
            default: begin
                exp_now = (mtick == PERIOD - 1);
                mtick = (mtick + 1) % PERIOD;
                for (int k = 0; k < 3; k++) begin
                    if (hrel[k] && HI[k] != 0) begin
                        mh[k] = (mh[k] + int'(hamt[k])) % (1 << HW);
                        mpend[k] = 1'b1;
                    end
                    if (drel[k] && DI[k] != 0) begin
                        md[k] = (md[k] + int'(damt[k])) % (1 << DW);
                        mpend[k] = 1'b1;
                    end
                    if (exp_now) mpend[k] = 1'b1;
                end
                if (hs) begin
                    mv = 0;
                end else if (!mv) begin
                    for (int k = 0; k < 3; k++) begin
                        c = (mnext + k) % 3;
                        if (mpend[c]) begin
                            m_issue(c, 1'b0);
                            mpend[c] = 1'b0;
                            mnext = (c + 1) % 3;
                            break;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic compare();
        check("valid", fc.fc_req_valid_o, mv);
        check("init_done", init_done, mdone);
        if (mv) begin
            check("init", fc.fc_req_init_o, mi);
            check("type", fc.fc_req_type_o, mt);
            check("hdr", fc.fc_req_hdr_o, mhdr);
            check("data", fc.fc_req_data_o, mdata);
        end
    endtask

    task automatic step();
        if (fc.fc_req_valid_o && fc.fc_req_ready_i)
            q_acc.push_back({fc.fc_req_init_o, fc.fc_req_type_o,
                             fc.fc_req_hdr_o, fc.fc_req_data_o});
        @(posedge clk);
        if (rst) m_reset();
        else model_edge();
        #1;
        compare();
    endtask

    task automatic chk_acc(string name, int idx, int i, int t, int h, int d);
        if (idx < q_acc.size()) begin
            check({name, "_init"}, q_acc[idx].i, i);
            check({name, "_type"}, q_acc[idx].t, t);
            check({name, "_hdr"}, q_acc[idx].h, h);
            check({name, "_data"}, q_acc[idx].d, d);
        end else begin
            check({name, "_missing"}, q_acc.size(), idx + 1);
        end
    endtask

    task automatic pulse_h(int c, int amt);
        hrel[c] = 1'b1;
        hamt[c] = HW'(amt);
        step();
        hrel[c] = 1'b0;
    endtask

    task automatic pulse_d(int c, int amt);
        drel[c] = 1'b1;
        damt[c] = DW'(amt);
        step();
        drel[c] = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        link_up = 1'b0;
        fc.fc_req_ready_i = 1'b0;
        hrel = '0;
        drel = '0;
        for (int c = 0; c < 3; c++) begin
            hamt[c] = '0;
            damt[c] = '0;
        end
        m_reset();
        repeat (3) step();
        check("rst_valid", fc.fc_req_valid_o, 0);
        check("rst_init", fc.fc_req_init_o, 0);
        check("rst_type", fc.fc_req_type_o, 0);
        check("rst_hdr", fc.fc_req_hdr_o, 0);
        check("rst_data", fc.fc_req_data_o, 0);
        check("rst_done", init_done, 0);
        rst = 1'b0;
        step();

        // InitFC sequence, ready tied high
        fc.fc_req_ready_i = 1'b1;
        link_up = 1'b1;
        q_acc.delete();
        repeat (16) step();
        check("init_count", q_acc.size(), 6);
        chk_acc("init0", 0, 1, 0, 32, 256);
        chk_acc("init1", 1, 1, 1, 16, 16);
        chk_acc("init2", 2, 1, 2, 0, 0);
        chk_acc("init3", 3, 1, 0, 32, 256);
        chk_acc("init4", 4, 1, 1, 16, 16);
        chk_acc("init5", 5, 1, 2, 0, 0);
        check("init_done_lit", init_done, 1);

        // PD release -> one P UpdateFC
        q_acc.delete();
        pulse_d(0, 8);
        repeat (4) step();
        check("pd_count", q_acc.size(), 1);
        chk_acc("pd_upd", 0, 0, 0, 32, 264);

        // PH wrap: 32 + 218 = 250, then +10 wraps to 4
        q_acc.delete();
        pulse_h(0, 218);
        repeat (4) step();
        pulse_h(0, 10);
        repeat (4) step();
        chk_acc("ph250", 0, 0, 0, 250, 264);
        chk_acc("ph_wrap", 1, 0, 0, 4, 264);

        // Stall with a release in the middle
        q_acc.delete();
        fc.fc_req_ready_i = 1'b0;
        pulse_h(0, 1);
        step();
        step();
        pulse_h(0, 1);
        step();
        step();
        fc.fc_req_ready_i = 1'b1;
        repeat (6) step();
        check("stall_count", q_acc.size(), 2);
        chk_acc("stall_a", 0, 0, 0, 5, 264);
        chk_acc("stall_b", 1, 0, 0, 6, 264);

        // Infinite CPLH: release ignored, then timer refreshes all three
        q_acc.delete();
        pulse_h(2, 5);
        repeat (4) step();
        check("cplh_no_req", q_acc.size(), 0);
        for (int n = 0; n < 2 * PERIOD && q_acc.size() < 3; n++) step();
        repeat (2) step();
        check("refresh_count", q_acc.size(), 3);
        chk_acc("refresh0", 0, 0, 1, 16, 16);
        chk_acc("refresh1", 1, 0, 2, 0, 0);
        chk_acc("refresh2", 2, 0, 0, 6, 264);

        // Link drop mid-INIT
        link_up = 1'b0;
        step();
        link_up = 1'b1;
        repeat (3) step();
        link_up = 1'b0;
        step();
        check("drop_init_valid", fc.fc_req_valid_o, 0);
        check("drop_init_done", init_done, 0);
        link_up = 1'b1;
        q_acc.delete();
        repeat (4) step();
        chk_acc("reinit_a", 0, 1, 0, 32, 256);
        repeat (12) step();
        check("reinit_done", init_done, 1);

        // Link drop mid-stall
        fc.fc_req_ready_i = 1'b0;
        pulse_d(0, 4);
        repeat (3) step();
        check("stall_hold", fc.fc_req_valid_o, 1);
        link_up = 1'b0;
        step();
        check("drop_stall_valid", fc.fc_req_valid_o, 0);
        check("drop_stall_done", init_done, 0);
        link_up = 1'b1;
        fc.fc_req_ready_i = 1'b1;
        q_acc.delete();
        repeat (3) step();
        chk_acc("reinit_b", 0, 1, 0, 32, 256);

        // Random traffic against the model
        repeat (3000) begin
            link_up = ($urandom_range(0, 399) != 0);
            fc.fc_req_ready_i = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < 3; c++) begin
                hrel[c] = ($urandom_range(0, 4) == 0);
                drel[c] = ($urandom_range(0, 4) == 0);
                hamt[c] = HW'($urandom);
                damt[c] = DW'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
